// File: rtl/perf_pkg.sv
// -----------------------------------------------------------------------------
// perf_pkg
// Shared definitions for the performance-counter family: the default counter
// width and the windowed-sampler state type. Users of the upstream
// performance counter import this package so that counter widths agree.
// -----------------------------------------------------------------------------
package perf_pkg;

    // Default width of the free-running performance counters and of every
    // count/delta derived from them.
    localparam int PERF_COUNTER_WIDTH = 32;

    // Windowed sampler control states.
    //   IDLE : not sampling; waiting for enable with a non-zero window length
    //   ARM  : capture baseline counter values and the window length
    //   RUN  : accumulate until the window length has elapsed
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } perf_state_e;

endpackage : perf_pkg

// File: rtl/perf_window_sampler.sv
// -----------------------------------------------------------------------------
// perf_window_sampler
// Turns two free-running performance counters (blocks processed, cycles
// elapsed) into back-to-back fixed-length measurement windows. At the end of
// each window the block and cycle deltas are offered to a consumer through a
// valid/ready holding register; running statistics (largest block delta and
// number of completed windows) are kept alongside, plus a sticky overrun flag
// for windows whose sample could not be delivered.
//
// Ports
//   clk              in   clock
//   rst_n            in   synchronous active-low reset
//   blocks_processed in   free-running block count          [COUNTER_WIDTH]
//   cycles_elapsed   in   free-running cycle count          [COUNTER_WIDTH]
//   enable           in   level; start / continue sampling
//   window_cycles    in   window length, taken in ARM       [WINDOW_WIDTH]
//   clear            in   pulse; clears statistics
//   sample_ready     in   consumer accepts the held sample
//   sample_valid     out  a sample is held
//   sample_blocks    out  blocks completed in the window    [COUNTER_WIDTH]
//   sample_cycles    out  cycles spanned by the window      [COUNTER_WIDTH]
//   max_blocks       out  largest captured block delta      [COUNTER_WIDTH]
//   window_count     out  windows completed                 [COUNTER_WIDTH]
//   overrun          out  sticky; a window ended while a sample was pending
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module perf_window_sampler
    import perf_pkg::*;
#(
    parameter int COUNTER_WIDTH = PERF_COUNTER_WIDTH,
    parameter int WINDOW_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COUNTER_WIDTH-1:0] blocks_processed,
    input  logic [COUNTER_WIDTH-1:0] cycles_elapsed,
    input  logic                     enable,
    input  logic [WINDOW_WIDTH-1:0]  window_cycles,
    input  logic                     clear,
    input  logic                     sample_ready,
    output logic                     sample_valid,
    output logic [COUNTER_WIDTH-1:0] sample_blocks,
    output logic [COUNTER_WIDTH-1:0] sample_cycles,
    output logic [COUNTER_WIDTH-1:0] max_blocks,
    output logic [COUNTER_WIDTH-1:0] window_count,
    output logic                     overrun
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WINDOW_WIDTH-1:0]  WIN_ZERO = {WINDOW_WIDTH{1'b0}};

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    perf_state_e               r_state;
    logic [COUNTER_WIDTH-1:0]  r_base_blocks;
    logic [COUNTER_WIDTH-1:0]  r_base_cycles;
    logic [WINDOW_WIDTH-1:0]   r_win_len;
    logic                      r_sample_valid;
    logic [COUNTER_WIDTH-1:0]  r_sample_blocks;
    logic [COUNTER_WIDTH-1:0]  r_sample_cycles;
    logic [COUNTER_WIDTH-1:0]  r_max_blocks;
    logic [COUNTER_WIDTH-1:0]  r_window_count;
    logic                      r_overrun;

    // -------------------------------------------------------------------------
    // Wires
    // -------------------------------------------------------------------------
    perf_state_e               w_next_state;
    logic                      w_in_arm;
    logic                      w_in_run;
    logic [COUNTER_WIDTH-1:0]  w_win_len_ext;
    logic [COUNTER_WIDTH-1:0]  w_delta_cycles;
    logic [COUNTER_WIDTH-1:0]  w_delta_blocks;
    logic                      w_win_end;
    logic                      w_capture;
    logic                      w_drop;
    logic                      w_release;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; dropping enable abandons any partial window.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (enable && (window_cycles != WIN_ZERO)) begin
                    w_next_state = ARM;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ARM: begin
                if (enable) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (enable) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM output decode. A RUN cycle with enable low is the exit cycle and
    // must not be allowed to close a window.
    always_comb begin
        w_in_arm = 1'b0;
        w_in_run = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_arm = 1'b0;
                w_in_run = 1'b0;
            end
            ARM: begin
                w_in_arm = 1'b1;
                w_in_run = 1'b0;
            end
            RUN: begin
                w_in_arm = 1'b0;
                w_in_run = enable;
            end
            default: begin
                w_in_arm = 1'b0;
                w_in_run = 1'b0;
            end
        endcase
    end

    // Unsigned subtraction wraps modulo 2^COUNTER_WIDTH, so a counter that
    // rolls over inside a window still yields the true elapsed amount.
    assign w_win_len_ext  = COUNTER_WIDTH'(r_win_len);
    assign w_delta_cycles = cycles_elapsed   - r_base_cycles;
    assign w_delta_blocks = blocks_processed - r_base_blocks;
    assign w_win_end      = w_in_run && (w_delta_cycles >= w_win_len_ext);

    // A finished window is stored when the holding register is free or is
    // being emptied this very cycle; otherwise the new result is lost.
    assign w_capture = w_win_end && (!r_sample_valid || sample_ready);
    assign w_drop    = w_win_end && r_sample_valid && !sample_ready;
    assign w_release = !w_win_end && r_sample_valid && sample_ready;

    // Baseline and window length: loaded in ARM, re-based at every window
    // end so the next window starts in the same cycle with no gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base_blocks <= CNT_ZERO;
            r_base_cycles <= CNT_ZERO;
            r_win_len     <= WIN_ZERO;
        end else if (w_in_arm) begin
            r_base_blocks <= blocks_processed;
            r_base_cycles <= cycles_elapsed;
            r_win_len     <= window_cycles;
        end else if (w_win_end) begin
            r_base_blocks <= blocks_processed;
            r_base_cycles <= cycles_elapsed;
            r_win_len     <= r_win_len;
        end else begin
            r_base_blocks <= r_base_blocks;
            r_base_cycles <= r_base_cycles;
            r_win_len     <= r_win_len;
        end
    end

    // Sample holding register with valid/ready handshake; contents are frozen
    // while a sample waits to be accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sample_valid  <= 1'b0;
            r_sample_blocks <= CNT_ZERO;
            r_sample_cycles <= CNT_ZERO;
        end else if (w_capture) begin
            r_sample_valid  <= 1'b1;
            r_sample_blocks <= w_delta_blocks;
            r_sample_cycles <= w_delta_cycles;
        end else if (w_release) begin
            r_sample_valid  <= 1'b0;
            r_sample_blocks <= r_sample_blocks;
            r_sample_cycles <= r_sample_cycles;
        end else begin
            r_sample_valid  <= r_sample_valid;
            r_sample_blocks <= r_sample_blocks;
            r_sample_cycles <= r_sample_cycles;
        end
    end

    // Peak block delta over captured samples only. When clear coincides with
    // a capture the fresh delta becomes the new peak rather than zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_max_blocks <= CNT_ZERO;
        end else if (w_capture && (clear || (w_delta_blocks > r_max_blocks))) begin
            r_max_blocks <= w_delta_blocks;
        end else if (clear) begin
            r_max_blocks <= CNT_ZERO;
        end else begin
            r_max_blocks <= r_max_blocks;
        end
    end

    // Completed-window counter; clear takes priority over a same-cycle end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_window_count <= CNT_ZERO;
        end else if (clear) begin
            r_window_count <= CNT_ZERO;
        end else if (w_win_end) begin
            r_window_count <= r_window_count + CNT_ONE;
        end else begin
            r_window_count <= r_window_count;
        end
    end

    // Sticky overrun flag; clear takes priority over a same-cycle drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    assign sample_valid  = r_sample_valid;
    assign sample_blocks = r_sample_blocks;
    assign sample_cycles = r_sample_cycles;
    assign max_blocks    = r_max_blocks;
    assign window_count  = r_window_count;
    assign overrun       = r_overrun;

endmodule : perf_window_sampler

// File: tb/tb_perf_window_sampler.sv
// -----------------------------------------------------------------------------
// tb_perf_window_sampler
// Self-checking bench for perf_window_sampler. The bench plays the upstream
// performance counter (cycles_elapsed +1 per clock, blocks_processed +1 per
// block pulse). A behavioural model built on 64-bit arithmetic with explicit
// modulo tracks every output each cycle; directed scenarios additionally
// check hand-derived constants.
// -----------------------------------------------------------------------------
module tb_perf_window_sampler;

    localparam int     CW  = 32;
    localparam int     WW  = 16;
    localparam longint MOD = 64'sd4294967296;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] blocks_processed = '0;
    logic [CW-1:0] cycles_elapsed = '0;
    logic          enable = 1'b0;
    logic [WW-1:0] window_cycles = '0;
    logic          clear = 1'b0;
    logic          sample_ready = 1'b0;
    logic          sample_valid;
    logic [CW-1:0] sample_blocks;
    logic [CW-1:0] sample_cycles;
    logic [CW-1:0] max_blocks;
    logic [CW-1:0] window_count;
    logic          overrun;

    perf_window_sampler #(.COUNTER_WIDTH(CW), .WINDOW_WIDTH(WW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .blocks_processed (blocks_processed),
        .cycles_elapsed   (cycles_elapsed),
        .enable           (enable),
        .window_cycles    (window_cycles),
        .clear            (clear),
        .sample_ready     (sample_ready),
        .sample_valid     (sample_valid),
        .sample_blocks    (sample_blocks),
        .sample_cycles    (sample_cycles),
        .max_blocks       (max_blocks),
        .window_count     (window_count),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    // Directed window scenarios: inputs (window, block period) and the
    // expected sample contents and running peak after two windows.
    typedef struct {
        int     win;
        int     period;
        longint exp_blocks;
        longint exp_cycles;
        longint exp_max;
    } scen_t;

    scen_t scen [4];

    int n_pass  = 0;
    int n_total = 0;
    int gtick   = 0;

    // Reference model state (spec-level quantities, not RTL registers).
    int     m_mode  = 0;   // 0 idle, 1 arm, 2 run
    longint m_bc    = 0;
    longint m_bb    = 0;
    longint m_len   = 0;
    bit     m_valid = 1'b0;
    longint m_sb    = 0;
    longint m_sc    = 0;
    longint m_max   = 0;
    longint m_cnt   = 0;
    bit     m_ovr   = 1'b0;

    function automatic longint mdelta(input longint a, input longint b);
        return (a - b + MOD) % MOD;
    endfunction

    function automatic bit pulse(input int p);
        return (gtick % p) == 0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT is about to see.
    task automatic model_step();
        longint ce;
        longint bp;
        longint dc;
        longint db;
        bit     wend;
        bit     took;
        int     nmode;
        ce   = longint'(cycles_elapsed);
        bp   = longint'(blocks_processed);
        took = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_bc = 0; m_bb = 0; m_len = 0;
            m_valid = 1'b0; m_sb = 0; m_sc = 0;
            m_max = 0; m_cnt = 0; m_ovr = 1'b0;
        end else begin
            dc   = mdelta(ce, m_bc);
            db   = mdelta(bp, m_bb);
            wend = (m_mode == 2) && enable && (dc >= m_len);
            case (m_mode)
                0:       nmode = (enable && (window_cycles != 0)) ? 1 : 0;
                1, 2:    nmode = enable ? 2 : 0;
                default: nmode = 0;
            endcase
            if (m_mode == 1) begin
                m_bc = ce; m_bb = bp; m_len = longint'(window_cycles);
            end
            if (wend) begin
                m_bc  = ce;
                m_bb  = bp;
                m_cnt = (m_cnt + 1) % MOD;
                if (!m_valid || sample_ready) begin
                    took    = 1'b1;
                    m_valid = 1'b1;
                    m_sb    = db;
                    m_sc    = dc;
                    if (clear || (db > m_max)) m_max = db;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && sample_ready) begin
                m_valid = 1'b0;
            end
            if (clear) begin
                m_cnt = 0;
                m_ovr = 1'b0;
                if (!took) m_max = 0;
            end
            m_mode = nmode;
        end
    endtask

    task automatic compare_all();
        chk("sample_valid",  longint'(sample_valid),  longint'(m_valid));
        chk("sample_blocks", longint'(sample_blocks), m_sb);
        chk("sample_cycles", longint'(sample_cycles), m_sc);
        chk("max_blocks",    longint'(max_blocks),    m_max);
        chk("window_count",  longint'(window_count),  m_cnt);
        chk("overrun",       longint'(overrun),       longint'(m_ovr));
    endtask

    // One clock: model, edge, compare, then advance the upstream counters.
    task automatic tick(input bit blk);
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        cycles_elapsed = cycles_elapsed + 32'd1;
        if (blk) blocks_processed = blocks_processed + 32'd1;
        gtick++;
    endtask

    task automatic run_ticks(input int n, input int p);
        for (int i = 0; i < n; i++) tick(pulse(p));
    endtask

    // Tick until sample_valid is seen; returns ticks taken or -1 on timeout.
    task automatic wait_valid(input int bound, input int p, output int taken);
        taken = -1;
        for (int i = 1; i <= bound; i++) begin
            tick(pulse(p));
            if (sample_valid) begin
                taken = i;
                break;
            end
        end
        if (taken < 0) chk("wait_valid_timeout", 0, 1);
    endtask

    initial begin
        int     seen;
        int     t;
        int     taken;
        bit     any;
        longint prev_cnt;

        scen[0] = '{100, 5, 20, 100, 20};
        scen[1] = '{50,  1, 50, 50,  50};
        scen[2] = '{50, 10,  5, 50,  50};
        scen[3] = '{64,  4, 16, 64,  50};

        // Reset state.
        rst_n = 1'b0;
        run_ticks(3, 3);
        chk("rst_valid",  longint'(sample_valid),  0);
        chk("rst_blocks", longint'(sample_blocks), 0);
        chk("rst_max",    longint'(max_blocks),    0);
        chk("rst_wcount", longint'(window_count),  0);
        chk("rst_ovr",    longint'(overrun),       0);
        rst_n = 1'b1;

        // window_cycles == 0 keeps the block idle.
        enable = 1'b1; window_cycles = 16'd0; sample_ready = 1'b1;
        any = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            if (sample_valid || (window_count != 0)) any = 1'b1;
        end
        chk("zero_window_idle", longint'(any), 0);
        enable = 1'b0;
        run_ticks(2, 1);

        // Table-driven steady-state windows.
        for (int s = 0; s < 4; s++) begin
            seen = 0; t = 0; prev_cnt = 0;
            enable = 1'b1; window_cycles = 16'(scen[s].win); sample_ready = 1'b1;
            while ((seen < 2) && (t < 3 * scen[s].win + 20)) begin
                tick(pulse(scen[s].period));
                t++;
                if (sample_valid) begin
                    seen++;
                    chk("scen_blocks", longint'(sample_blocks), scen[s].exp_blocks);
                    chk("scen_cycles", longint'(sample_cycles), scen[s].exp_cycles);
                    if (seen == 2) begin
                        chk("scen_wcount_step", longint'(window_count) - prev_cnt, 1);
                        chk("scen_max", longint'(max_blocks), scen[s].exp_max);
                    end
                    prev_cnt = longint'(window_count);
                end
            end
            if (seen < 2) chk("scen_timeout", 0, 1);
            enable = 1'b0;
            run_ticks(3, scen[s].period);
        end

        // Back-pressure across two window ends, then release.
        enable = 1'b1; window_cycles = 16'd20; sample_ready = 1'b0;
        run_ticks(45, 2);
        chk("bp_valid",   longint'(sample_valid),  1);
        chk("bp_blocks",  longint'(sample_blocks), 10);
        chk("bp_cycles",  longint'(sample_cycles), 20);
        chk("bp_overrun", longint'(overrun),       1);
        sample_ready = 1'b1;
        tick(pulse(2));
        chk("bp_release", longint'(sample_valid), 0);
        wait_valid(40, 2, taken);
        chk("bp_next_blocks", longint'(sample_blocks), 10);
        chk("bp_next_cycles", longint'(sample_cycles), 20);
        enable = 1'b0;
        run_ticks(3, 2);

        // Enable dropped mid-window, then a full window after re-enable.
        enable = 1'b1; window_cycles = 16'd100;
        run_ticks(40, 5);
        enable = 1'b0;
        any = 1'b0;
        for (int i = 0; i < 130; i++) begin
            tick(pulse(5));
            if (sample_valid) any = 1'b1;
        end
        chk("drop_no_sample", longint'(any), 0);
        enable = 1'b1;
        wait_valid(150, 5, taken);
        chk("rearm_latency", longint'(taken), 102);
        chk("rearm_blocks",  longint'(sample_blocks), 20);
        chk("rearm_cycles",  longint'(sample_cycles), 100);
        enable = 1'b0;
        run_ticks(3, 5);

        // Counter wrap inside a window.
        cycles_elapsed   = 32'hFFFF_FFC0;
        blocks_processed = 32'hFFFF_FFF0;
        enable = 1'b1; window_cycles = 16'd100;
        wait_valid(150, 4, taken);
        chk("wrap_cycles", longint'(sample_cycles), 100);
        chk("wrap_blocks", longint'(sample_blocks), 25);

        // Reset with a held sample mid-window.
        window_cycles = 16'd10; sample_ready = 1'b0;
        wait_valid(40, 2, taken);
        run_ticks(5, 2);
        rst_n = 1'b0;
        tick(1'b0);
        chk("hrst_valid",  longint'(sample_valid),  0);
        chk("hrst_blocks", longint'(sample_blocks), 0);
        chk("hrst_cycles", longint'(sample_cycles), 0);
        chk("hrst_max",    longint'(max_blocks),    0);
        chk("hrst_wcount", longint'(window_count),  0);
        chk("hrst_ovr",    longint'(overrun),       0);
        rst_n = 1'b1; enable = 1'b0;
        run_ticks(2, 2);

        // Clear coinciding with a window end (ends at ticks 12, 22, 32).
        enable = 1'b1; window_cycles = 16'd10; sample_ready = 1'b0;
        run_ticks(31, 2);
        chk("pre_clear_ovr",    longint'(overrun),      1);
        chk("pre_clear_wcount", longint'(window_count), 2);
        clear = 1'b1; sample_ready = 1'b1;
        tick(pulse(2));
        clear = 1'b0;
        chk("clr_end_wcount", longint'(window_count), 0);
        chk("clr_end_ovr",    longint'(overrun),      0);
        chk("clr_end_max",    longint'(max_blocks),   5);
        chk("clr_end_valid",  longint'(sample_valid), 1);
        enable = 1'b0;
        run_ticks(3, 2);
        clear = 1'b1;
        tick(1'b0);
        clear = 1'b0;
        chk("clr_max", longint'(max_blocks), 0);

        // Randomised traffic against the model.
        enable = 1'b1; window_cycles = 16'd7;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if (!enable && ($urandom_range(0, 3) == 0))
                window_cycles = 16'($urandom_range(0, 30));
            sample_ready = ($urandom_range(0, 2) != 0);
            clear        = ($urandom_range(0, 59) == 0);
            tick($urandom_range(0, 1) == 1);
        end
        clear = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_perf_window_sampler

// File: doc/perf_window_sampler.md
PERF_WINDOW_SAMPLER -- requirements
Module: perf_window_sampler

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 32, width of the counter inputs and the sample outputs.
REQ-002 SHALL have parameter WINDOW_WIDTH, default 16, width of window_cycles.
REQ-003 SHALL have one clock, one reset, both on the same clock domain; reset is synchronous and active-low.
REQ-004 SHALL have port clk  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port blocks_processed  input  COUNTER_WIDTH  free-running block count from the upstream performance counter.
REQ-007 SHALL have port cycles_elapsed  input  COUNTER_WIDTH  free-running cycle count from the upstream performance counter; increments by 1 every clock.
REQ-008 SHALL have port enable  input  1  level; start or continue windowed sampling.
REQ-009 SHALL have port window_cycles  input  WINDOW_WIDTH  window length in cycles; sampled only in ARM.
REQ-010 SHALL have port clear  input  1  single-cycle pulse; clears statistics.
REQ-011 SHALL have port sample_ready  input  1  consumer accepts a sample.
REQ-012 SHALL have port sample_valid  output  1  a sample is held.
REQ-013 SHALL have port sample_blocks  output  COUNTER_WIDTH  blocks completed in the window.
REQ-014 SHALL have port sample_cycles  output  COUNTER_WIDTH  cycles spanned by the window.
REQ-015 SHALL have port max_blocks  output  COUNTER_WIDTH  largest sample_blocks captured since reset or clear.
REQ-016 SHALL have port window_count  output  COUNTER_WIDTH  number of windows completed.
REQ-017 SHALL have port overrun  output  1  sticky; a window completed while the previous sample was still unaccepted.

Function
REQ-018 SHALL implement states IDLE, ARM and RUN.
REQ-019 IDLE->ARM SHALL occur when enable=1 and window_cycles!=0; with window_cycles==0 the block SHALL stay in IDLE.
REQ-020 ARM SHALL latch base_blocks, base_cycles and the window length from the current inputs, then go to RUN on the next cycle.
REQ-021 In RUN, window end SHALL be detected when (cycles_elapsed - base_cycles), computed modulo 2^COUNTER_WIDTH, is >= the latched window length, so counter wrap-around is transparent.
REQ-022 At window end, the block SHALL compute blocks_processed - base_blocks and cycles_elapsed - base_cycles, both modulo 2^COUNTER_WIDTH.
REQ-023 At window end, the block SHALL re-baseline to the current counter values in the same cycle, giving back-to-back windows with no gap.
REQ-024 At window end, window_count SHALL increment, wrapping modulo 2^COUNTER_WIDTH.
REQ-025 If sample_valid=0 at window end, the deltas SHALL be registered to sample_blocks and sample_cycles, and sample_valid SHALL rise the next cycle (latency 1).
REQ-026 If sample_valid=1 and sample_ready=0 at window end, the held sample SHALL be kept, the new sample dropped and overrun set.
REQ-027 If sample_valid=1 and sample_ready=1 at window end, the new sample SHALL replace the old one, sample_valid SHALL stay 1 and overrun SHALL be unchanged.
REQ-028 sample_valid=1 with sample_ready=1 and no window end SHALL clear sample_valid the next cycle.
REQ-029 sample_blocks and sample_cycles SHALL stay stable while sample_valid=1 and sample_ready=0.
REQ-030 max_blocks SHALL update to the captured delta when that delta > max_blocks; dropped samples SHALL NOT update max_blocks.
REQ-031 enable=0 in ARM or RUN SHALL return the block to IDLE next cycle, discard the partial window and keep any held sample until it is accepted.
REQ-032 clear SHALL zero max_blocks, window_count and overrun next cycle and SHALL NOT affect the state, the baseline or a held sample.
REQ-033 If clear and a window end occur in the same cycle, clear SHALL win for window_count and overrun, and max_blocks SHALL load the new delta.

Reset
REQ-034 rst_n=0 at a clk edge SHALL force state IDLE and zero sample_valid, sample_blocks, sample_cycles, max_blocks, window_count, overrun and the baseline registers.
REQ-035 Reset asserted mid-window SHALL discard the window, with no sample produced after reset release until a new ARM.

Structure
REQ-036 Package perf_pkg SHALL hold the COUNTER_WIDTH default and the state enum type (IDLE, ARM, RUN), shared with performance_counter users.
REQ-037 The block SHALL be a single module with no sub-module, and all outputs SHALL be driven directly from registers.

Verification
REQ-038 Window=100, block pulse every 5 cycles, sample_ready=1 -> each sample has sample_blocks=20, sample_cycles=100, and window_count increments by 1 per window.
REQ-039 Continuous block_completed, window=50 -> sample_blocks=50 and max_blocks=50; then pulses every 10 cycles -> sample_blocks=5 and max_blocks stays 50.
REQ-040 sample_ready=0 across two window ends -> first sample stays stable, overrun=1; after sample_ready=1 for one cycle -> sample_valid=0, next sample correct.
REQ-041 Counters preset so cycles_elapsed wraps mid-window (base 0xFFFFFFC0, window=100) -> sample_cycles=100, and block delta is correct across the wrap.
REQ-042 enable dropped at cycle 40 of a 100-cycle window -> no sample, state IDLE; re-enable -> ARM then a full 100-cycle window.
REQ-043 rst_n=0 mid-window with a held sample -> all outputs zero next cycle; clear pulsed during a window end -> window_count=0 and overrun=0.
